conv_pim_ctrl: RTL and testbench

Sequencer for one `conv_pim` convolution engine. It streams KERNEL_SIZE-wide input columns of one row band into the engine's shift-register input stage and steps the weight address through every stored filter for each window position. It waits the fixed PIM array latency, then delivers each `convValue` downstream over a valid/ready handshake. It sits between the feature-map line buffer (upstream) and the pooling/activation stage (downstream) in the LeNet-5 PIM pipeline.

---
 rtl/pim_pkg.sv | 29 ++
 rtl/pim_lat_counter.sv | 34 +++
 rtl/conv_pim_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_conv_pim_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pim_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pim_pkg
// Description : Shared types and helpers for the PIM convolution / FC control.
// Revision    : 1.0
// ============================================================================
package pim_pkg;

    localparam int DEFAULT_PIM_LAT = 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_WAIT = 3'd2,
        S_EMIT = 3'd3,
        S_NEXT = 3'd4,
        S_DONE = 3'd5
    } conv_ctrl_state_t;

    // Bits needed to index 0..value-1, never less than one.
    function automatic int clog2_w(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w = w + 1;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pim_lat_counter.sv
`default_nettype none
// ============================================================================
// Module      : pim_lat_counter
// Description : Loadable down-counter with zero flag for PIM array latency.
// Revision    : 1.0
// ============================================================================
module pim_lat_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // Load wins over decrement; the count rests at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/conv_pim_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : conv_pim_ctrl
// Description : Column/filter sequencer for one conv_pim engine, one row band.
// Revision    : 1.0
// ============================================================================
module conv_pim_ctrl
    import pim_pkg::*;
#(
    parameter int BIT_WIDTH   = 8,
    parameter int OUT_WIDTH   = 8,
    parameter int KERNEL_SIZE = 5,
    parameter int IN_SIZE     = 32,
    parameter int NUM_FILTERS = 2,
    parameter int ADDR_W      = 1,
    parameter int PIM_LAT     = DEFAULT_PIM_LAT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    input  logic                        col_valid,
    output logic                        col_ready,
    output logic                        pim_en,
    output logic [ADDR_W-1:0]           pim_address,
    input  logic [OUT_WIDTH-1:0]        pim_value,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_WIDTH-1:0]        out_data,
    output logic [clog2_w(IN_SIZE)-1:0] out_col,
    output logic [ADDR_W-1:0]           out_filter
);

    localparam int c_COL_W = clog2_w(KERNEL_SIZE + 1);
    localparam int c_WIN_W = clog2_w(IN_SIZE);
    localparam int c_LAT_W = clog2_w(PIM_LAT);

    localparam logic [c_COL_W-1:0] c_KSIZE     = c_COL_W'(KERNEL_SIZE);
    localparam logic [c_COL_W-1:0] c_LAST_COL  = c_COL_W'(KERNEL_SIZE - 1);
    localparam logic [c_WIN_W-1:0] c_LAST_WIN  = c_WIN_W'(IN_SIZE - KERNEL_SIZE);
    localparam logic [ADDR_W-1:0]  c_LAST_FILT = ADDR_W'(NUM_FILTERS - 1);
    localparam logic [c_LAT_W-1:0] c_LAT_LOAD  = c_LAT_W'(PIM_LAT - 1);

    if ((IN_SIZE < KERNEL_SIZE) || (PIM_LAT < 1) || (BIT_WIDTH < 1) ||
        (ADDR_W < clog2_w(NUM_FILTERS))) begin : g_param_check
        $error("conv_pim_ctrl: invalid parameterisation");
    end

    conv_ctrl_state_t   r_state;
    conv_ctrl_state_t   w_next_state;
    logic [c_COL_W-1:0] r_col_cnt;
    logic [c_WIN_W-1:0] r_window;
    logic [ADDR_W-1:0]  r_filter;
    logic               w_lat_load;
    logic               w_lat_zero;

    pim_lat_counter #(
        .WIDTH (c_LAT_W)
    ) u_lat_counter (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_lat_load),
        .i_load_value (c_LAT_LOAD),
        .i_dec        (r_state == S_WAIT),
        .o_zero       (w_lat_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The latency counter is reloaded on every transition into WAIT.
    always_comb begin
        w_next_state = r_state;
        w_lat_load   = 1'b0;
        col_ready    = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next_state = S_FILL;
            end
            S_FILL: begin
                col_ready = 1'b1;
                if (col_valid && (r_col_cnt == c_LAST_COL)) begin
                    w_next_state = S_WAIT;
                    w_lat_load   = 1'b1;
                end
            end
            S_WAIT: begin
                if (w_lat_zero) w_next_state = S_EMIT;
            end
            S_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (r_filter < c_LAST_FILT) begin
                        w_next_state = S_WAIT;
                        w_lat_load   = 1'b1;
                    end else if (r_window == c_LAST_WIN) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                col_ready = 1'b1;
                if (col_valid) begin
                    w_next_state = S_WAIT;
                    w_lat_load   = 1'b1;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign pim_en = col_valid & col_ready;

    // pim_address is a separate register so it only moves on WAIT entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col_cnt   <= '0;
            r_window    <= '0;
            r_filter    <= '0;
            pim_address <= '0;
            out_data    <= '0;
            out_col     <= '0;
            out_filter  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_col_cnt <= '0;
                        r_window  <= '0;
                        r_filter  <= '0;
                    end
                end
                S_FILL: begin
                    if (col_valid) begin
                        if (r_col_cnt < c_KSIZE) r_col_cnt <= r_col_cnt + 1'b1;
                        if (r_col_cnt == c_LAST_COL) begin
                            r_filter    <= '0;
                            pim_address <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_lat_zero) begin
                        out_data   <= pim_value;
                        out_col    <= r_window;
                        out_filter <= r_filter;
                    end
                end
                S_EMIT: begin
                    if (out_ready && (r_filter < c_LAST_FILT)) begin
                        r_filter    <= r_filter + 1'b1;
                        pim_address <= r_filter + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (col_valid) begin
                        if (r_window < c_LAST_WIN) r_window <= r_window + 1'b1;
                        r_filter    <= '0;
                        pim_address <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_pim_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_pim_ctrl
// Description : Directed scoreboard bench for conv_pim_ctrl with engine model.
// Revision    : 1.0
// ============================================================================
module tb_conv_pim_ctrl;
    import pim_pkg::*;

    localparam int BIT_WIDTH   = 8;
    localparam int OUT_WIDTH   = 8;
    localparam int KERNEL_SIZE = 5;
    localparam int IN_SIZE     = 8;
    localparam int NUM_FILTERS = 2;
    localparam int ADDR_W      = 1;
    localparam int PIM_LAT     = 4;
    localparam int COL_W       = clog2_w(IN_SIZE);
    localparam int N_WIN       = IN_SIZE - KERNEL_SIZE + 1;
    localparam int BAND_CYCLES = KERNEL_SIZE + N_WIN * NUM_FILTERS * (PIM_LAT + 1)
                                 + (IN_SIZE - KERNEL_SIZE) + 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic                 col_valid;
    logic                 col_ready;
    logic                 pim_en;
    logic [ADDR_W-1:0]    pim_address;
    logic [OUT_WIDTH-1:0] pim_value;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic [COL_W-1:0]     out_col;
    logic [ADDR_W-1:0]    out_filter;

    typedef struct packed {
        logic [OUT_WIDTH-1:0] data;
        logic [COL_W-1:0]     col;
        logic [ADDR_W-1:0]    filt;
    } exp_t;

    exp_t sb[$];
    int   checks     = 0;
    int   errors     = 0;
    int   cyc        = 0;
    int   tb_cols    = 0;
    int   age        = 0;
    int   pim_en_cnt = 0;
    int   done_cnt   = 0;

    always #5 clk = ~clk;

    conv_pim_ctrl #(
        .BIT_WIDTH   (BIT_WIDTH),
        .OUT_WIDTH   (OUT_WIDTH),
        .KERNEL_SIZE (KERNEL_SIZE),
        .IN_SIZE     (IN_SIZE),
        .NUM_FILTERS (NUM_FILTERS),
        .ADDR_W      (ADDR_W),
        .PIM_LAT     (PIM_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .col_valid   (col_valid),
        .col_ready   (col_ready),
        .pim_en      (pim_en),
        .pim_address (pim_address),
        .pim_value   (pim_value),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_col     (out_col),
        .out_filter  (out_filter)
    );

    // Engine model: value 16*window+filter, garbage until PIM_LAT cycles settle.
    assign pim_value = ((age >= PIM_LAT - 1) && (tb_cols >= KERNEL_SIZE))
                       ? OUT_WIDTH'(16 * (tb_cols - KERNEL_SIZE) + int'(pim_address))
                       : 8'hEE;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clock_step();
        int n_cols;
        int n_age;
        #1;
        n_cols = tb_cols;
        n_age  = age;
        if (pim_en) begin
            if (n_cols < IN_SIZE) n_cols++;
            n_age = 0;
        end else if (out_valid && out_ready) begin
            n_age = 0;
        end else if (n_age < 100) begin
            n_age++;
        end
        if (pim_en) pim_en_cnt++;
        if (done) done_cnt++;
        @(posedge clk);
        #1;
        tb_cols = n_cols;
        age     = n_age;
        cyc++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_col_ready"}, col_ready, 0);
        chk({tag, "_pim_en"}, pim_en, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_pim_address"}, pim_address, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_col"}, out_col, 0);
        chk({tag, "_out_filter"}, out_filter, 0);
    endtask

    task automatic run_band(input int hold_idx, input bit fill_stall, input bit spam_start,
                            input bit abort_w2);
        int   n_acc   = 0;
        int   hold    = 0;
        int   stall   = 3;
        int   guard   = 0;
        int   c5      = -1;
        int   cv      = -1;
        int   cols    = 0;
        int   s_cyc;
        int   en0;
        int   done0;
        bit   fin     = 0;
        bit   aborted = 0;
        exp_t e;

        for (int w = 0; w < N_WIN; w++)
            for (int f = 0; f < NUM_FILTERS; f++) begin
                e.data = OUT_WIDTH'(16 * w + f);
                e.col  = COL_W'(w);
                e.filt = ADDR_W'(f);
                sb.push_back(e);
            end
        en0       = pim_en_cnt;
        done0     = done_cnt;
        tb_cols   = 0;
        start     = 1'b1;
        col_valid = 1'b1;
        out_ready = 1'b1;
        s_cyc     = cyc;
        clock_step();

        while (!fin && !aborted && guard < 20 * BAND_CYCLES) begin
            guard++;
            start     = spam_start && !done;
            cols      = pim_en_cnt - en0;
            col_valid = !(fill_stall && cols == 2 && stall > 0);
            if (!col_valid) stall--;
            out_ready = 1'b1;
            if (n_acc == hold_idx && out_valid && hold < 7) begin
                out_ready = 1'b0;
                hold++;
            end
            #1;
            if (!out_ready) begin
                chk("hold_out_data", out_data, 8'h11);
                chk("hold_out_col", out_col, 1);
                chk("hold_out_filter", out_filter, 1);
                chk("hold_col_ready", col_ready, 0);
                chk("hold_pim_en", pim_en, 0);
            end
            if (pim_en && cols == KERNEL_SIZE - 1) c5 = cyc;
            if (c5 >= 0 && cyc == c5 + 1) chk("addr_on_first_wait", pim_address, 0);
            if (out_valid && cv < 0) begin
                cv = cyc;
                chk("first_out_latency", cv - c5, PIM_LAT + 1);
                chk("pim_en_before_wait", pim_en_cnt - en0, KERNEL_SIZE);
            end
            if (out_valid && out_ready) begin
                chk("sb_has_entry", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_col", out_col, e.col);
                    chk("out_filter", out_filter, e.filt);
                end
                n_acc++;
            end
            if (done) begin
                fin = 1;
                if (hold_idx < 0 && !fill_stall) chk("band_time", cyc - s_cyc, BAND_CYCLES);
            end
            if (abort_w2 && n_acc == 2 * NUM_FILTERS && busy && !out_valid && !col_ready) begin
                rst = 1'b0;
                #1;
                chk_all_zero("abort_reset");
                sb.delete();
                clock_step();
                clock_step();
                rst = 1'b1;
                for (int i = 0; i < 4; i++) clock_step();
                chk("abort_no_done", done_cnt - done0, 0);
                chk("abort_idle", busy, 0);
                aborted = 1;
            end else begin
                clock_step();
            end
        end

        start = 1'b0;
        if (abort_w2) begin
            chk("abort_reached", aborted, 1);
        end else begin
            chk("band_finished", fin, 1);
            chk("band_outputs", n_acc, N_WIN * NUM_FILTERS);
            chk("sb_drained", sb.size(), 0);
            chk("band_pim_en", pim_en_cnt - en0, IN_SIZE);
            chk("band_done_pulses", done_cnt - done0, 1);
            #1;
            chk("post_band_busy", busy, 0);
            chk("post_band_done", done, 0);
            clock_step();
        end
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        col_valid = 1'b0;
        out_ready = 1'b0;
        clock_step();
        clock_step();
        chk_all_zero("reset");
        rst = 1'b1;
        clock_step();
        chk("idle_busy", busy, 0);

        run_band(-1, 1'b0, 1'b0, 1'b0);
        run_band(3, 1'b0, 1'b0, 1'b0);
        run_band(-1, 1'b1, 1'b0, 1'b0);
        run_band(-1, 1'b0, 1'b0, 1'b1);
        run_band(-1, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
